// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 3x3 convolution path.
// Imported by the frame sequencer, fetch and filter blocks.
package conv_pkg;

    localparam int N        = 256;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 17;
    localparam int LAST_IDX = N * N - 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller: walks every pixel of one frame through
// window fetch, filter and output write, one pixel at a time.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int N      = conv_pkg::N,
    parameter int ADDR_W = conv_pkg::ADDR_W,
    parameter int DATA_W = conv_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pix_idx,
    output logic              fetch_go,
    input  logic              fetch_ready,
    output logic              win_valid,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N * N - 1);

    state_t state;

    // The write address is the registered pixel index itself.
    assign wr_addr = pix_idx;

    // Sequencer FSM with registered strobes and pixel counter.
    // fetch_go / win_valid being high marks the first cycle of
    // FETCH / FILT, so a handshake level seen then is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_idx   <= '0;
            fetch_go  <= 1'b0;
            win_valid <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fetch_go  <= 1'b0;
            win_valid <= 1'b0;
            wr_en     <= 1'b0;
        end else begin
            fetch_go  <= 1'b0;
            win_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        fetch_go <= 1'b1;
                        pix_idx  <= '0;
                    end
                end
                FETCH: begin
                    if (fetch_ready && !fetch_go) begin
                        state     <= FILT;
                        win_valid <= 1'b1;
                    end
                end
                FILT: begin
                    if (res_valid && !win_valid) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_data <= res_data;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        if (pix_idx == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            fetch_go <= 1'b1;
                            pix_idx  <= pix_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the 3x3 convolution path. It walks pixel index 0..N*N-1 across one image and, for each pixel, fires the window-fetch unit and waits for its nine-tap window. It then triggers the filter datapath, captures the filtered result, and writes it to the output frame buffer at the same index. It sits between the host start/done control and the fetch, filter and output-RAM blocks.

## Interface
- `N`, 256, image side length in pixels (N x N frame).
- `ADDR_W`, 16, pixel index / address width; N*N-1 must fit.
- `DATA_W`, 17, pixel/result data width.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `abort`  in  1  cancel the frame in progress.
- `busy`  out  1  high from the first cycle after an accepted start until return to IDLE.
- `done`  out  1  one-cycle pulse after the last pixel write completes.
- `pix_idx`  out  ADDR_W  current pixel index; drives the fetch unit's centre index.
- `fetch_go`  out  1  one-cycle pulse: start window fetch for `pix_idx`.
- `fetch_ready`  in  1  window complete (taps valid).
- `win_valid`  out  1  one-cycle pulse: the filter may consume the window.
- `res_valid`  in  1  filter result valid.
- `res_data`  in  DATA_W  filter result.
- `wr_en`  out  1  output RAM write request.
- `wr_addr`  out  ADDR_W  write address, equal to `pix_idx`.
- `wr_data`  out  DATA_W  registered result.
- `wr_ready`  in  1  output RAM accepts the write this cycle.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH → FILT on `fetch_ready`.
  - FILT → WRITE on `res_valid`.
  - WRITE → FETCH on `wr_ready` if `pix_idx` < N*N-1.
  - WRITE → DONE on `wr_ready` if `pix_idx` = N*N-1.
  - DONE → IDLE unconditionally.
- `fetch_go` pulses on the first cycle of each FETCH visit.
  - `fetch_ready` is honoured only from the cycle after `fetch_go`. A level left over from the previous window is ignored.
- `win_valid` pulses on the first cycle of FILT.
  - `res_valid` is honoured only from the cycle after `win_valid`.
- `res_data` is captured into `wr_data` on the accepted `res_valid`. It is held stable while `wr_en` = 1.
- In WRITE, `wr_en` stays high until `wr_ready`. The write completes in that cycle, `wr_en` drops the next cycle, and `pix_idx` increments at the same edge.
- Increment rule:
  - Compare `pix_idx` against N*N-1 before incrementing.
  - There is no wrap to 0 inside a frame.
  - `pix_idx` returns to 0 only on entry to FETCH from IDLE.
- `abort` in any non-IDLE state: next state IDLE, all strobes low, no `done`.
  - `abort` and `start` in the same IDLE cycle: abort wins, stay IDLE.
- `start` while busy: ignored.
- `fetch_ready` or `res_valid` outside its waiting state: ignored.
- Reset values: state IDLE, `busy` 0, `done` 0, `pix_idx` 0, `fetch_go` 0, `win_valid` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0.
- `rst` mid-frame behaves as `abort`, and additionally clears `pix_idx` and `wr_data`.

## Timing
- All outputs are registered.
- `start` high at edge t → `busy` = 1, `fetch_go` = 1, `pix_idx` = 0 during cycle t+1.
- `fetch_ready` sampled at edge f → `win_valid` = 1 during cycle f+1.
- `res_valid` sampled at edge r → `wr_en` = 1 with `wr_data` = `res_data` during cycle r+1.
- `wr_ready` sampled at edge w:
  - mid-frame → `fetch_go` = 1 with `pix_idx`+1 during cycle w+1;
  - last pixel → `done` = 1 during w+1, `busy` = 0 during w+2.
- Per-pixel controller overhead is 3 cycles beyond fetch, filter and write latencies.
- A zero-wait-state RAM (`wr_ready` tied high) costs 1 write cycle per pixel.

## Structure
- Shared package `conv_pkg`:
  - constants `N`, `ADDR_W`, `DATA_W`;
  - localparam `LAST_IDX` = N*N-1;
  - state encoding IDLE/FETCH/FILT/WRITE/DONE.
- The fetch and filter units import the same constants.
- Single module: no sub-module. The index counter and FSM are tightly coupled.

## Test plan
- N=4 (sim override): `start`; fetch model answers 10 cycles after `fetch_go`; filter answers 2 cycles after `win_valid` with `res_data` = idx*3; `wr_ready` tied 1 → 16 writes, addr 0..15, data 0,3,…,45; one `done` pulse; `busy` low after.
- Backpressure: `wr_ready` held 0 for 5 cycles at idx 7 → `wr_en`, `wr_addr` = 7, `wr_data` = 21 held stable for 6 cycles; `pix_idx` stays 7 until accept.
- Stale strobes: `fetch_ready` high in the same cycle as `fetch_go`, and `res_valid` pulsed during FETCH → both ignored; no extra writes; write order unchanged.
- `abort` asserted while in FILT at idx 9 → IDLE next cycle, no `done`, no further `wr_en`. New `start` → frame restarts at idx 0.
- `start` and `abort` together in IDLE → stays IDLE, `busy` 0. `start` pulsed mid-frame → ignored; total writes = 16.
- `rst` asserted at idx 5 in WRITE → next cycle all outputs at their reset values.
